uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
- Parametrised UART receive core: start detection, oversampled majority-vote sampling, LSB-first deserialisation, parity and stop checking.
- Counters and checkers are integrated with the control FSM.
- Successor to the fixed 8-bit RX controller. Generic data width, runtime prescale of 8/16/32, even/odd parity, 1 or 2 stop bits.
- Errors are reported per frame instead of silently aborting.
- Sits between the RX pin synchroniser and the RX async FIFO in the UART subsystem.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (5..9).
- PRESC_W, 6, width of the Prescale input and the internal edge counter.

Ports:
- CLK, input, 1, oversampling clock.
- RST, input, 1, asynchronous active-low reset.
- RX_IN, input, 1, serial line. Already synchronised to CLK externally. Idle high.
- Prescale, input, PRESC_W, oversampling ratio. Legal values are 8, 16, 32.
- PAR_EN, input, 1, parity bit present.
- PAR_TYP, input, 1, 0 = even, 1 = odd.
- STOP2, input, 1, 1 = two stop bits.
- P_DATA, output, DATA_WIDTH, received payload. Held until the next frame completes.
- data_valid, output, 1, one-cycle pulse: frame good.
- par_err, output, 1, one-cycle pulse at frame end: parity mismatch.
- stp_err, output, 1, one-cycle pulse at frame end: a stop bit sampled 0.
- cfg_err, output, 1, level: Prescale illegal, receiver held in IDLE.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset:
  - All outputs 0; FSM in IDLE; counters and shift register 0.
  - Reset mid-frame discards the frame with no pulse.
- Configuration:
  - Prescale, PAR_EN, PAR_TYP and STOP2 are latched on the start-detect cycle.
  - Changes mid-frame are ignored.
- cfg_err:
  - Combinational on the live Prescale.
  - While high, IDLE does not leave on a low RX_IN.
- Counters:
  - edge_cnt runs 0..P-1 per bit, where P is the latched Prescale. It wraps to 0 and increments bit_cnt.
  - The start-detect cycle is edge 0 of the start bit.
- Sampling:
  - Samples are taken at edges P/2-1, P/2 and P/2+1.
  - The majority of the three samples is the bit value.
  - The decision edge is P/2+2.
- IDLE:
  - RX_IN==0 and !cfg_err -> START on the next cycle, with edge_cnt=1.
- START:
  - At the decision edge, majority 1 (glitch) -> IDLE, no output.
  - Otherwise at edge P-1 -> DATA, bit_cnt=0.
- DATA:
  - At the decision edge the bit is shifted in LSB-first.
  - At edge P-1 with bit_cnt==DATA_WIDTH-1 -> PARITY if PAR_EN, else STOP.
- PARITY:
  - Expected parity = XOR of the data, inverted when PAR_TYP=1.
  - At the decision edge, a mismatch sets an internal par_flag.
  - At edge P-1 -> STOP. The frame is never aborted.
- STOP:
  - At each stop bit's decision edge, a sample of 0 sets stp_flag.
  - With STOP2, the first stop bit runs to edge P-1 and then the second is sampled.
  - At the decision edge of the last stop bit -> IDLE on the next cycle. The remainder of the stop bit is not waited for, so the next start edge can be caught early.
- Frame end (registered, the cycle after the last stop-bit decision edge):
  - P_DATA is loaded regardless of errors.
  - data_valid = !par_flag && !stp_flag.
  - par_err = par_flag; stp_err = stp_flag.
  - The flags are then cleared.
- Latency (no parity, one stop bit): data_valid rises (DATA_WIDTH+1)*P + P/2 + 3 cycles after the start-detect cycle.
- Back-to-back frames:
  - RX_IN low in the cycle IDLE is re-entered starts a new frame.
  - No lost cycles.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- When defined:
  - Extra output break_det, 1 bit, reset 0.
  - Pulses together with the frame-end pulses when all data bits, the parity bit (if present) and all stop bits sampled 0.
  - data_valid is suppressed for that frame; stp_err still pulses.
  - The FSM then stays in IDLE until RX_IN has been 1 for one full P cycles.
- When undefined: no port, no logic. A break reports as a stp_err frame.

Decomposition:
- Package uart_rx_pkg holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP);
  - PRESC_8/16/32 constants;
  - a parity function.
- Sub-module uart_rx_sampler: the three-sample majority voter. Inputs are edge_cnt, P and RX_IN; outputs are bit value and sample_done.

Test Plan:
- P=8, no parity, 1 stop, frame 0xA5 -> P_DATA=0xA5; data_valid single pulse at cycle 79 after start detect; par_err=stp_err=0.
- P=16, PAR_EN=1, PAR_TYP=0, 0x3C sent with parity bit 1 -> par_err pulse, data_valid=0, P_DATA=0x3C.
- P=8, RX_IN low for 3 cycles then high -> glitch rejected, busy back to 0 by cycle 7, no pulses.
- P=32, STOP2=1, second stop bit forced 0 -> stp_err pulse, data_valid=0.
- P=8, frames 0x01 and 0xFE back-to-back with zero idle -> two data_valid pulses 80 cycles apart, correct data in both.
- Prescale=12 -> cfg_err=1 and a low RX_IN is ignored. Mid-frame RST low -> all outputs 0, no pulse after release.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive core: FSM states, legal prescale
// values, and the bit-level helper functions used by the core and sampler.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int PRESC_8    = 8;
  localparam int PRESC_16   = 16;
  localparam int PRESC_32   = 32;
  localparam int MAX_DATA_W = 9;

  // Expected parity bit: even parity is the XOR of the payload, odd inverts it.
  function automatic logic exp_parity(input logic [MAX_DATA_W-1:0] data,
                                      input logic                  odd);
    return (^data) ^ odd;
  endfunction

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Three-sample majority voter: captures RX_IN at edges P/2-1, P/2, P/2+1 and
// presents the voted bit with sample_done on the decision edge P/2+2.
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [PRESC_W-1:0] edge_cnt,
  input  logic [PRESC_W-1:0] presc,
  input  logic               rx_in,
  output logic               bit_val,
  output logic               sample_done
);

  logic [PRESC_W-1:0] half;
  logic [2:0]         smp_q;
  logic [2:0]         smp_d;

  assign half = presc >> 1;

  always_comb begin
    smp_d = smp_q;
    if (edge_cnt == half - PRESC_W'(1)) smp_d[0] = rx_in;
    if (edge_cnt == half)               smp_d[1] = rx_in;
    if (edge_cnt == half + PRESC_W'(1)) smp_d[2] = rx_in;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp_q <= '0;
    end else begin
      smp_q <= smp_d;
    end
  end

  assign bit_val     = majority3(smp_q);
  assign sample_done = (edge_cnt == half + PRESC_W'(2));

endmodule

// File: rtl/uart_rx_core.sv
// UART receive core: start detect, majority-vote sampling, LSB-first shift,
// parity and stop checking with per-frame error pulses.
// Define UART_RX_BREAK_DET_EN to add the break_det output and break hold-off.
module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  cfg_err,
`ifdef UART_RX_BREAK_DET_EN
  output logic                  break_det,
`endif
  output logic                  busy
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  rx_state_e             state_q, state_d;
  logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic                  par_flag_q, par_flag_d;
  logic                  stp_flag_q, stp_flag_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
`ifdef UART_RX_BREAK_DET_EN
  logic                  brk_all0_q, brk_all0_d;
  logic                  brk_wait_q, brk_wait_d;
  logic                  break_det_q, break_det_d;
  logic                  all0_now;
`endif

  logic                  bit_val;
  logic                  sample_done;
  logic                  edge_last;
  logic [PRESC_W-1:0]    edge_nxt;
  logic                  stp_now;

  uart_rx_sampler #(
    .PRESC_W(PRESC_W)
  ) u_sampler (
    .CLK        (CLK),
    .RST        (RST),
    .edge_cnt   (edge_cnt_q),
    .presc      (presc_q),
    .rx_in      (RX_IN),
    .bit_val    (bit_val),
    .sample_done(sample_done)
  );

  assign cfg_err = (Prescale != PRESC_W'(PRESC_8)) &&
                   (Prescale != PRESC_W'(PRESC_16)) &&
                   (Prescale != PRESC_W'(PRESC_32));

  assign edge_last = (edge_cnt_q == presc_q - PRESC_W'(1));
  assign edge_nxt  = edge_last ? '0 : edge_cnt_q + PRESC_W'(1);
  // Stop error including the stop bit being decided this cycle.
  assign stp_now   = stp_flag_q | ~bit_val;

  always_comb begin
    state_d      = state_q;
    edge_cnt_d   = edge_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    presc_d      = presc_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    stop2_d      = stop2_q;
    par_flag_d   = par_flag_q;
    stp_flag_d   = stp_flag_q;
    p_data_d     = p_data_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
    brk_all0_d   = brk_all0_q;
    brk_wait_d   = brk_wait_q;
    break_det_d  = 1'b0;
    all0_now     = brk_all0_q & ~bit_val;
`endif

    case (state_q)
      IDLE: begin
        edge_cnt_d = '0;
        bit_cnt_d  = '0;
`ifdef UART_RX_BREAK_DET_EN
        // After a break, count consecutive high cycles before re-arming.
        if (brk_wait_q) begin
          if (RX_IN) begin
            if (edge_last) brk_wait_d = 1'b0;
            else           edge_cnt_d = edge_nxt;
          end
        end else
`endif
        if (!RX_IN && !cfg_err) begin
          state_d    = START;
          edge_cnt_d = PRESC_W'(1);
          presc_d    = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          stop2_d    = STOP2;
          par_flag_d = 1'b0;
          stp_flag_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
          brk_all0_d = 1'b1;
`endif
        end
      end

      START: begin
        edge_cnt_d = edge_nxt;
        if (sample_done && bit_val) begin
          state_d    = IDLE;
          edge_cnt_d = '0;
        end else if (edge_last) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end

      DATA: begin
        edge_cnt_d = edge_nxt;
        if (sample_done) begin
          shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
`ifdef UART_RX_BREAK_DET_EN
          brk_all0_d = all0_now;
`endif
        end
        if (edge_last) begin
          if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
            state_d   = par_en_q ? PARITY : STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      PARITY: begin
        edge_cnt_d = edge_nxt;
        if (sample_done) begin
          if (bit_val != exp_parity(MAX_DATA_W'(shift_q), par_typ_q)) par_flag_d = 1'b1;
`ifdef UART_RX_BREAK_DET_EN
          brk_all0_d = all0_now;
`endif
        end
        if (edge_last) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end

      STOP: begin
        edge_cnt_d = edge_nxt;
        if (sample_done) begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            stp_flag_d = stp_now;
`ifdef UART_RX_BREAK_DET_EN
            brk_all0_d = all0_now;
`endif
          end else begin
            // Last stop bit decided: leave early so the next start edge is caught.
            state_d    = IDLE;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
            p_data_d   = shift_q;
            par_err_d  = par_flag_q;
            stp_err_d  = stp_now;
            par_flag_d = 1'b0;
            stp_flag_d = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            break_det_d  = all0_now;
            brk_wait_d   = all0_now;
            data_valid_d = !par_flag_q && !stp_now && !all0_now;
`else
            data_valid_d = !par_flag_q && !stp_now;
`endif
          end
        end else if (edge_last) begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      edge_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      stop2_q      <= 1'b0;
      par_flag_q   <= 1'b0;
      stp_flag_q   <= 1'b0;
      p_data_q     <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
      brk_all0_q   <= 1'b0;
      brk_wait_q   <= 1'b0;
      break_det_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      edge_cnt_q   <= edge_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      presc_q      <= presc_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      stop2_q      <= stop2_d;
      par_flag_q   <= par_flag_d;
      stp_flag_q   <= stp_flag_d;
      p_data_q     <= p_data_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
`ifdef UART_RX_BREAK_DET_EN
      brk_all0_q   <= brk_all0_d;
      brk_wait_q   <= brk_wait_d;
      break_det_q  <= break_det_d;
`endif
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign busy       = (state_q != IDLE);
`ifdef UART_RX_BREAK_DET_EN
  assign break_det  = break_det_q;
`endif

endmodule
